// File: rtl/mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings, latencies, FSM states.
package mdu_pkg;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;
    localparam int unsigned MDU_OP_W        = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Execute-stage bus between the pipeline (master) and the MDU (slave).
interface mdu_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDUOp, start, input busy, HI, LO);
    modport slave  (input A, B, MDUOp, start, output busy, HI, LO);

endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO; result is computed at
// start and held in a pending register until the busy period expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    mdu_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic [63:0]      res_d;

    mdu_op_e     op;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [63:0] a_sx;
    logic [63:0] b_sx;

    assign op = mdu_op_e'(bus.MDUOp);

    // 64-bit result for the sampled op; divide-by-zero keeps the current HI/LO.
    always_comb begin
        res_d      = {hi_q, lo_q};
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & bus.A[31];
        b_neg      = div_signed & bus.B[31];
        a_mag      = a_neg ? 32'(-bus.A) : bus.A;
        b_mag      = b_neg ? 32'(-bus.B) : bus.B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        a_sx       = {{32{bus.A[31]}}, bus.A};
        b_sx       = {{32{bus.B[31]}}, bus.B};
        case (op)
            OP_MULT:  res_d = a_sx * b_sx;
            OP_MULTU: res_d = {32'd0, bus.A} * {32'd0, bus.B};
            OP_DIV, OP_DIVU: begin
                if (bus.B != 32'd0) begin
                    res_d = {(a_neg ? 32'(-r_mag) : r_mag),
                             ((a_neg ^ b_neg) ? 32'(-q_mag) : q_mag)};
                end
            end
            default: res_d = {hi_q, lo_q};
        endcase
    end

    // Idle/run FSM with down-counter; HI/LO only move on mthi/mtlo or run completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                {pend_hi_q, pend_lo_q} <= res_d;
                                cnt_q                  <= CNT_W'(MULT_CYCLES);
                                busy_q                 <= 1'b1;
                                state_q                <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                {pend_hi_q, pend_lo_q} <= res_d;
                                cnt_q                  <= CNT_W'(DIV_CYCLES);
                                busy_q                 <= 1'b1;
                                state_q                <= S_RUN;
                            end
                            OP_MTHI: hi_q <= bus.A;
                            OP_MTLO: lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops against
// a 64-bit arithmetic reference model.
module tb_mdu;

    localparam int BUSY_LIMIT = 40;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_if bus ();

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural result of an op as {HI, LO}, given the current HI/LO.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {hi, lo};
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = 64'(ua * ub);
            3'd3: if (b != 0) begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) begin
                res = {32'(ua % ub), 32'(ua / ub)};
            end
            3'd5: res = {a, lo};
            3'd6: res = {hi, a};
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    function automatic int ref_cycles(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    // Present one start cycle; returns at the falling edge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Count falling edges with busy high; flag any HI/LO movement meanwhile.
    task automatic count_busy(output int n, output bit moved);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0   = bus.HI;
        lo0   = bus.LO;
        n     = 0;
        moved = 1'b0;
        while (bus.busy === 1'b1 && n < BUSY_LIMIT) begin
            if (bus.HI !== hi0 || bus.LO !== lo0) moved = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    // Issue an op, wait out its busy period, advance the model.
    task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit moved);
        logic [63:0] r;
        r = ref_result(op, a, b, m_hi, m_lo);
        issue(op, a, b);
        count_busy(n, moved);
        {m_hi, m_lo} = r;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", bus.HI); end
        checks++; if (bus.LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", bus.LO); end
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_mult_signed();
        int n;
        bit moved;
        exec(3'd1, 32'hFFFFFFFD, 32'd5, n, moved);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL mult_hilo_early: HI/LO changed while busy, expected held"); end
        checks++; if (bus.HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected ffffffff", bus.HI); end
        checks++; if (bus.LO !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo: got %h expected fffffff1", bus.LO); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit moved;
        exec(3'd2, 32'hFFFFFFFF, 32'd2, n, moved);
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
        checks++; if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFE) begin
            failures++; $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", bus.HI, bus.LO);
        end
        exec(3'd3, 32'hFFFFFFF9, 32'd2, n, moved);
        checks++; if (n !== 10) begin failures++; $display("FAIL b2b_div_busy_cycles: got %0d expected 10", n); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL b2b_div_hilo_early: HI/LO changed while busy"); end
        checks++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
            failures++; $display("FAIL b2b_div_result: got %h_%h expected ffffffff_fffffffd", bus.HI, bus.LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd5, 32'h12345678, 32'd0);
        checks++; if (bus.HI !== 32'h12345678 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL mthi: got HI=%h busy=%b expected 12345678 busy=0", bus.HI, bus.busy);
        end
        issue(3'd6, 32'h9ABCDEF0, 32'd0);
        checks++; if (bus.LO !== 32'h9ABCDEF0 || bus.HI !== 32'h12345678 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL mtlo: got HI=%h LO=%h busy=%b expected 12345678 9abcdef0 busy=0", bus.HI, bus.LO, bus.busy);
        end
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_div_by_zero();
        int n;
        bit moved;
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        m_hi = 32'h11;
        m_lo = 32'h22;
        exec(3'd4, 32'd7, 32'd0, n, moved);
        checks++; if (n !== 10) begin failures++; $display("FAIL divzero_busy_cycles: got %0d expected 10", n); end
        checks++; if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
            failures++; $display("FAIL divzero_result: got %h_%h expected 00000011_00000022", bus.HI, bus.LO);
        end
        exec(3'd3, 32'h80000000, 32'hFFFFFFFF, n, moved);
        checks++; if (n !== 10) begin failures++; $display("FAIL div_ovf_busy_cycles: got %0d expected 10", n); end
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h80000000) begin
            failures++; $display("FAIL div_ovf_result: got %h_%h expected 00000000_80000000", bus.HI, bus.LO);
        end
    endtask

    task automatic test_ignore_in_run();
        int          n;
        int          rest;
        bit          moved;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        a = $urandom;
        b = $urandom;
        r = ref_result(3'd1, a, b, m_hi, m_lo);
        issue(3'd1, a, b);
        n = 0;
        if (bus.busy === 1'b1) n++;
        bus.MDUOp = 3'd6; bus.A = 32'hDEADBEEF; bus.start = 1'b1;
        @(negedge clk);
        if (bus.busy === 1'b1) n++;
        bus.MDUOp = 3'd3; bus.A = 32'd100; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        count_busy(rest, moved);
        n += rest;
        {m_hi, m_lo} = r;
        checks++; if (n !== 5) begin failures++; $display("FAIL ignore_busy_cycles: got %0d expected 5", n); end
        checks++; if (bus.HI !== m_hi || bus.LO !== m_lo) begin
            failures++; $display("FAIL ignore_result: got %h_%h expected %h_%h", bus.HI, bus.LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_abort();
        bit stray;
        issue(3'd3, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            failures++; $display("FAIL abort_reset: got busy=%b HI=%h LO=%h expected 0 0 0", bus.busy, bus.HI, bus.LO);
        end
        reset_n = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin
            failures++; $display("FAIL abort_late_update: got busy=%b HI=%h LO=%h expected 0 0 0", bus.busy, bus.HI, bus.LO);
        end
    endtask

    task automatic test_random();
        int          n;
        bit          moved;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exec(op, a, b, n, moved);
            checks++; if (n !== ref_cycles(op) || moved !== 1'b0) begin
                failures++; $display("FAIL rand_timing[%0d] op=%0d: got cycles=%0d early=%b expected %0d 0", i, op, n, moved, ref_cycles(op));
            end
            checks++; if (bus.HI !== m_hi || bus.LO !== m_lo) begin
                failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, bus.HI, bus.LO, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_mthi_mtlo();
        test_div_by_zero();
        test_ignore_in_run();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the Execute stage, next to the ALU. It takes the same forwarded 32-bit operands and runs mult/multu/div/divu over several cycles into private HI/LO registers. It also serves mthi/mtlo writes and exposes HI/LO for mfhi/mflo. A `busy` output drives the hazard unit, which stalls any MDU instruction in Decode while the unit is occupied.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset_n  input  1  reset, synchronous and active-low
- A  input  32  operand rs (forwarded); dividend for div
- B  input  32  operand rt (forwarded); divisor for div
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- start  input  1  one-cycle qualifier; MDUOp/A/B are sampled when start=1
- busy  output  1  registered; 1 while a mult/div is in flight
- HI  output  32  registered HI register
- LO  output  32  registered LO register

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter `cnt`).
- IDLE, start=1, op mult/multu/div/divu:
  - compute the 64-bit result from A/B and latch it into pending_hi/pending_lo;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, op mthi/mtlo: HI<=A or LO<=A at that edge; stay IDLE.
- IDLE, start=1, op none/reserved: no effect.
- RUN, each edge: cnt<=cnt-1. On the edge where cnt==1: HI<=pending_hi, LO<=pending_lo, go to IDLE.
- start=1 while in RUN: ignored entirely, including mthi/mtlo. The hazard unit guarantees this never happens; the bench still checks it.
- HI/LO are not modified at any time during RUN.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 to 64.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (div or divu, B==0): the full DIV_CYCLES busy period still runs. pending_hi/pending_lo are loaded with the current HI/LO, so both are unchanged on completion.
- reset_n=0 at any edge: HI=0, LO=0, busy=0, cnt=0, state IDLE. An in-flight operation is discarded.

## Timing
- Reset values: busy=0, HI=0x00000000, LO=0x00000000.
- start sampled at edge E0. busy is 1 from E0 through E0+N-1 edges, i.e. exactly N cycles high, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at edge E0+N, the same edge busy falls. The new values are visible in the first cycle with busy=0.
- mthi/mtlo: HI/LO are visible the cycle after the start edge; busy stays 0.
- Back-to-back: start may be asserted in the first cycle with busy=0 and is accepted.
- The hazard unit stalls Decode on (start | busy) when Decode holds an MDU instruction. The MDU itself has no stall input.
- mfhi/mflo read the HI/LO ports combinationally in Execute; no read latency inside the MDU.

## Structure
- Shared CPU definitions package holds the MDUOp encodings and the MULT_CYCLES/DIV_CYCLES defaults.
- Single module; no sub-module is required.
- The 64-bit result compute is one combinational always block selected by MDUOp. The counter/FSM is a separate sequential block.

## Test plan
- Reset, then mult A=0xFFFFFFFD (-3), B=5 -> busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO keep their reset values (0) until busy falls.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; then immediate div A=0xFFFFFFF9 (-7), B=2 in the first idle cycle -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO show the values one cycle after each start; busy never asserts.
- From HI=0x11, LO=0x22, divu A=7, B=0 -> busy 10 cycles; HI=0x11, LO=0x22 afterwards. Then div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a mult busy period, pulse start with mtlo A=0xDEADBEEF and with div -> both ignored; busy still falls after exactly 5 cycles with the mult result.
- Start div, drive reset_n=0 on the 4th busy cycle -> next cycle busy=0, HI=0, LO=0; no later update from the aborted divide.
